// File: rtl/hololink_init_seq.sv
// Post-reset APB register initialisation sequencer.
// After a start delay it walks INIT_TABLE and issues each {addr, data} entry as an APB write on
// the downstream port. The host APB port is stalled until the walk completes, then becomes a
// zero-latency combinational pass-through.
module hololink_init_seq #(
   parameter int unsigned              N_INIT_REG     = 1,
   parameter logic [N_INIT_REG*64-1:0] INIT_TABLE     = {32'h0300_0210, 32'h004C_4B40},
   parameter int unsigned              START_DELAY    = 16,
   parameter int unsigned              TIMEOUT_CYCLES = 1024
) (
   input  logic                            i_apb_clk,
   input  logic                            i_apb_rst_n,
   input  logic                            i_start,
   input  logic                            i_h_psel,
   input  logic                            i_h_penable,
   input  logic                            i_h_pwrite,
   input  logic [31:0]                     i_h_paddr,
   input  logic [31:0]                     i_h_pwdata,
   output logic [31:0]                     o_h_prdata,
   output logic                            o_h_pready,
   output logic                            o_h_pslverr,
   output logic                            o_psel,
   output logic                            o_penable,
   output logic                            o_pwrite,
   output logic [31:0]                     o_paddr,
   output logic [31:0]                     o_pwdata,
   input  logic [31:0]                     i_prdata,
   input  logic                            i_pready,
   input  logic                            i_pslverr,
   output logic                            o_init_busy,
   output logic                            o_init_done,
   output logic                            o_init_err,
   output logic [$clog2(N_INIT_REG+1)-1:0] o_err_idx
);

   localparam int unsigned IdxW = $clog2(N_INIT_REG + 1);
   localparam int unsigned DlyW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
   localparam int unsigned ToW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [IdxW-1:0] LastIdx = IdxW'(N_INIT_REG - 1);
   localparam logic [DlyW-1:0] DlyLast = DlyW'(START_DELAY - 1);
   localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);

   // StGap is the one idle cycle inserted after an abandoned (timed-out) write.
   typedef enum logic [2:0] {StWait, StSetup, StAccess, StGap, StDone} state_e;

   state_e          state_q;
   logic [DlyW-1:0] dly_q;
   logic [ToW-1:0]  to_q;
   logic [IdxW-1:0] idx_q;
   logic            psel_q, penable_q, pwrite_q;
   logic [31:0]     paddr_q, pwdata_q;
   logic            busy_q, done_q, err_q, start_pend_q;
   logic [IdxW-1:0] err_idx_q;

   logic [IdxW-1:0] idx_nxt;
   logic [63:0]     entry0, entry_nxt;
   logic            pass;

   // Table lookup for the entry following idx (saturating at the last entry).
   always_comb begin
      idx_nxt   = (idx_q == LastIdx) ? idx_q : idx_q + 1'b1;
      entry0    = INIT_TABLE[63:0];
      entry_nxt = INIT_TABLE[63:0];
      for (int unsigned k = 0; k < N_INIT_REG; k++) begin
         if (idx_nxt == IdxW'(k)) entry_nxt = INIT_TABLE[k*64 +: 64];
      end
   end

   // Sequencer FSM with registered APB and status outputs.
   always_ff @(posedge i_apb_clk or negedge i_apb_rst_n) begin
      if (!i_apb_rst_n) begin
         state_q      <= StWait;
         dly_q        <= '0;
         to_q         <= '0;
         idx_q        <= '0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         err_idx_q    <= '0;
         start_pend_q <= 1'b0;
      end else begin
         case (state_q)
            StWait: begin
               if (dly_q == DlyLast) begin
                  state_q   <= StSetup;
                  idx_q     <= '0;
                  psel_q    <= 1'b1;
                  penable_q <= 1'b0;
                  pwrite_q  <= 1'b1;
                  paddr_q   <= entry0[63:32];
                  pwdata_q  <= entry0[31:0];
                  busy_q    <= 1'b1;
               end else begin
                  dly_q <= dly_q + 1'b1;
               end
            end
            StSetup: begin
               state_q   <= StAccess;
               penable_q <= 1'b1;
               to_q      <= '0;
            end
            StAccess: begin
               // A response in the expiry cycle still counts as a normal completion.
               if (i_pready) begin
                  if (i_pslverr) begin
                     err_q <= 1'b1;
                     if (!err_q) err_idx_q <= idx_q;
                  end
                  if (idx_q == LastIdx) begin
                     state_q   <= StDone;
                     psel_q    <= 1'b0;
                     penable_q <= 1'b0;
                     pwrite_q  <= 1'b0;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                  end else begin
                     // psel stays high so consecutive writes run back-to-back.
                     state_q   <= StSetup;
                     idx_q     <= idx_nxt;
                     penable_q <= 1'b0;
                     paddr_q   <= entry_nxt[63:32];
                     pwdata_q  <= entry_nxt[31:0];
                  end
               end else if (to_q == ToLast) begin
                  err_q <= 1'b1;
                  if (!err_q) err_idx_q <= idx_q;
                  state_q   <= StGap;
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  pwrite_q  <= 1'b0;
               end else begin
                  to_q <= to_q + 1'b1;
               end
            end
            StGap: begin
               if (idx_q == LastIdx) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q   <= StSetup;
                  idx_q     <= idx_nxt;
                  psel_q    <= 1'b1;
                  penable_q <= 1'b0;
                  pwrite_q  <= 1'b1;
                  paddr_q   <= entry_nxt[63:32];
                  pwdata_q  <= entry_nxt[31:0];
               end
            end
            StDone: begin
               // A rerun request waits until the host is not mid-transfer.
               if ((i_start || start_pend_q) && !i_h_psel) begin
                  state_q      <= StSetup;
                  idx_q        <= '0;
                  psel_q       <= 1'b1;
                  penable_q    <= 1'b0;
                  pwrite_q     <= 1'b1;
                  paddr_q      <= entry0[63:32];
                  pwdata_q     <= entry0[31:0];
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  err_q        <= 1'b0;
                  err_idx_q    <= '0;
                  start_pend_q <= 1'b0;
               end else if (i_start) begin
                  start_pend_q <= 1'b1;
               end
            end
            default: state_q <= StWait;
         endcase
      end
   end

   // Downstream port is owned by the sequencer until DONE, then by the host.
   assign pass        = (state_q == StDone);
   assign o_psel      = pass ? i_h_psel    : psel_q;
   assign o_penable   = pass ? i_h_penable : penable_q;
   assign o_pwrite    = pass ? i_h_pwrite  : pwrite_q;
   assign o_paddr     = pass ? i_h_paddr   : paddr_q;
   assign o_pwdata    = pass ? i_h_pwdata  : pwdata_q;
   assign o_h_prdata  = pass ? i_prdata    : 32'h0;
   assign o_h_pready  = pass & i_pready;
   assign o_h_pslverr = pass & i_pslverr;

   assign o_init_busy = busy_q;
   assign o_init_done = done_q;
   assign o_init_err  = err_q;
   assign o_err_idx   = err_idx_q;

endmodule

// File: tb/tb_hololink_init_seq.sv
// Directed bench for hololink_init_seq: one instance with the default single-entry table and
// one with a three-entry table, short start delay and an 8-cycle timeout.
module tb_hololink_init_seq;

   localparam logic [191:0] TblB = {32'h0000_0300, 32'h3333_3333,
                                    32'h0000_0200, 32'h2222_2222,
                                    32'h0000_0100, 32'h1111_1111};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Instance A signals
   logic        a_rst_n, a_start, a_h_psel, a_h_penable, a_h_pwrite;
   logic [31:0] a_h_paddr, a_h_pwdata, a_h_prdata;
   logic        a_h_pready, a_h_pslverr;
   logic        a_psel, a_penable, a_pwrite;
   logic [31:0] a_paddr, a_pwdata, a_prdata;
   logic        a_pready, a_pslverr, a_busy, a_done, a_err;
   logic [0:0]  a_eidx;

   // Instance B signals
   logic        b_rst_n, b_start, b_h_psel, b_h_penable, b_h_pwrite;
   logic [31:0] b_h_paddr, b_h_pwdata, b_h_prdata;
   logic        b_h_pready, b_h_pslverr;
   logic        b_psel, b_penable, b_pwrite;
   logic [31:0] b_paddr, b_pwdata, b_prdata;
   logic        b_pready, b_pslverr, b_busy, b_done, b_err;
   logic [1:0]  b_eidx;

   hololink_init_seq #(
      .N_INIT_REG(1),
      .START_DELAY(16)
   ) u_a (
      .i_apb_clk(clk), .i_apb_rst_n(a_rst_n), .i_start(a_start),
      .i_h_psel(a_h_psel), .i_h_penable(a_h_penable), .i_h_pwrite(a_h_pwrite),
      .i_h_paddr(a_h_paddr), .i_h_pwdata(a_h_pwdata),
      .o_h_prdata(a_h_prdata), .o_h_pready(a_h_pready), .o_h_pslverr(a_h_pslverr),
      .o_psel(a_psel), .o_penable(a_penable), .o_pwrite(a_pwrite),
      .o_paddr(a_paddr), .o_pwdata(a_pwdata),
      .i_prdata(a_prdata), .i_pready(a_pready), .i_pslverr(a_pslverr),
      .o_init_busy(a_busy), .o_init_done(a_done), .o_init_err(a_err), .o_err_idx(a_eidx)
   );

   hololink_init_seq #(
      .N_INIT_REG(3),
      .INIT_TABLE(TblB),
      .START_DELAY(4),
      .TIMEOUT_CYCLES(8)
   ) u_b (
      .i_apb_clk(clk), .i_apb_rst_n(b_rst_n), .i_start(b_start),
      .i_h_psel(b_h_psel), .i_h_penable(b_h_penable), .i_h_pwrite(b_h_pwrite),
      .i_h_paddr(b_h_paddr), .i_h_pwdata(b_h_pwdata),
      .o_h_prdata(b_h_prdata), .o_h_pready(b_h_pready), .o_h_pslverr(b_h_pslverr),
      .o_psel(b_psel), .o_penable(b_penable), .o_pwrite(b_pwrite),
      .o_paddr(b_paddr), .o_pwdata(b_pwdata),
      .i_prdata(b_prdata), .i_pready(b_pready), .i_pslverr(b_pslverr),
      .o_init_busy(b_busy), .o_init_done(b_done), .o_init_err(b_err), .o_err_idx(b_eidx)
   );

   // Cycle n = the period after the n-th rising edge since reset release.
   int a_cyc, b_cyc;
   always @(posedge clk or negedge a_rst_n) if (!a_rst_n) a_cyc <= 0; else a_cyc <= a_cyc + 1;
   always @(posedge clk or negedge b_rst_n) if (!b_rst_n) b_cyc <= 0; else b_cyc <= b_cyc + 1;

   // B slave: ready after b_ws wait states; optional hang on entry 0, errors on entries 1/2.
   int   b_ws   = 0;
   int   b_wcnt = 0;
   logic b_err1 = 1'b0, b_err2 = 1'b0, b_hang = 1'b0;
   always_comb begin
      b_pready  = b_psel && b_penable && (b_wcnt == b_ws) && !(b_hang && b_paddr == 32'h100);
      b_pslverr = b_pready && ((b_err1 && b_paddr == 32'h200) || (b_err2 && b_paddr == 32'h300));
   end
   always @(posedge clk) b_wcnt <= (b_psel && b_penable && !b_pready) ? b_wcnt + 1 : 0;

   // Cycles where B is busy but psel is low.
   int b_gaps = 0;
   always @(negedge clk) if (b_busy && !b_psel) b_gaps <= b_gaps + 1;

   logic [127:0] a_obs, b_obs;
   assign a_obs = {a_psel, a_penable, a_pwrite, a_paddr, a_pwdata, a_h_pready, a_h_prdata,
                   a_busy, a_done, a_err, a_eidx};
   assign b_obs = {b_psel, b_penable, b_pwrite, b_paddr, b_pwdata, b_busy, b_done, b_err, b_eidx};

   typedef struct {
      int          cyc;
      logic        psel, pen, pwr;
      logic [31:0] paddr, pwdata;
      logic        hrdy;
      logic [31:0] hrdata;
      logic        busy, done, err;
   } a_row_t;

   typedef struct {
      logic        hsel, hen, hwr;
      logic [31:0] haddr, hwdata, prdata;
      logic        prdy, perr;
      logic        e_psel, e_pen, e_pwr;
      logic [31:0] e_paddr, e_pwdata, e_hrdata;
      logic        e_hrdy, e_herr;
   } pt_vec_t;

   typedef struct {
      int          scen;
      int          cyc;
      logic        psel, pen;
      logic [31:0] paddr, pwdata;
      logic        busy, done, err;
      logic [1:0]  eidx;
   } b_row_t;

   typedef struct {
      int   ws;
      logic err1, err2, hang;
   } b_cfg_t;

   a_row_t  a_rows[5];
   pt_vec_t pt_vecs[3];
   b_row_t  b_rows[$];
   b_cfg_t  b_cfg[4];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic goto_a(input int t);
      for (int g = 0; g < 400 && a_cyc != t; g++) @(negedge clk);
      if (a_cyc != t) chk("goto_a", 128'(a_cyc), 128'(t));
   endtask

   task automatic goto_b(input int t);
      for (int g = 0; g < 400 && b_cyc != t; g++) @(negedge clk);
      if (b_cyc != t) chk("goto_b", 128'(b_cyc), 128'(t));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int gaps0;

      a_rows[0] = '{5,  1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
      a_rows[1] = '{15, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
      a_rows[2] = '{16, 1'b1, 1'b0, 1'b1, 32'h0300_0210, 32'h004C_4B40, 1'b0, 32'h0,
                    1'b1, 1'b0, 1'b0};
      a_rows[3] = '{17, 1'b1, 1'b1, 1'b1, 32'h0300_0210, 32'h004C_4B40, 1'b0, 32'h0,
                    1'b1, 1'b0, 1'b0};
      a_rows[4] = '{18, 1'b1, 1'b1, 1'b1, 32'h0000_1234, 32'hCAFE_F00D, 1'b1, 32'h5A5A_0001,
                    1'b0, 1'b1, 1'b0};

      pt_vecs[0] = '{1'b1, 1'b0, 1'b1, 32'hAAAA_0004, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b0,
                     1'b1, 1'b0, 1'b1, 32'hAAAA_0004, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b0};
      pt_vecs[1] = '{1'b1, 1'b1, 1'b0, 32'hBBBB_0008, 32'h0, 32'h0BAD_F00D, 1'b1, 1'b1,
                     1'b1, 1'b1, 1'b0, 32'hBBBB_0008, 32'h0, 32'h0BAD_F00D, 1'b1, 1'b1};
      pt_vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1357_9BDF, 1'b0, 1'b0,
                     1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1357_9BDF, 1'b0, 1'b0};

      b_cfg[0] = '{2, 1'b0, 1'b0, 1'b0};
      b_cfg[1] = '{0, 1'b1, 1'b1, 1'b0};
      b_cfg[2] = '{0, 1'b0, 1'b0, 1'b1};
      b_cfg[3] = '{7, 1'b0, 1'b0, 1'b0};

      // Two wait states per write: 1 SETUP + 3 ACCESS each, psel continuous.
      b_rows.push_back('{0, 3,  1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b0, 1'b0, 2'd0});
      b_rows.push_back('{0, 4,  1'b1, 1'b0, 32'h100, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 2'd0});
      b_rows.push_back('{0, 5,  1'b1, 1'b1, 32'h100, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 2'd0});
      b_rows.push_back('{0, 7,  1'b1, 1'b1, 32'h100, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 2'd0});
      b_rows.push_back('{0, 8,  1'b1, 1'b0, 32'h200, 32'h2222_2222, 1'b1, 1'b0, 1'b0, 2'd0});
      b_rows.push_back('{0, 11, 1'b1, 1'b1, 32'h200, 32'h2222_2222, 1'b1, 1'b0, 1'b0, 2'd0});
      b_rows.push_back('{0, 12, 1'b1, 1'b0, 32'h300, 32'h3333_3333, 1'b1, 1'b0, 1'b0, 2'd0});
      b_rows.push_back('{0, 15, 1'b1, 1'b1, 32'h300, 32'h3333_3333, 1'b1, 1'b0, 1'b0, 2'd0});
      b_rows.push_back('{0, 16, 1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b1, 1'b0, 2'd0});
      // PSLVERR on entries 1 and 2: first failing index kept, all writes issued.
      b_rows.push_back('{1, 6,  1'b1, 1'b0, 32'h200, 32'h2222_2222, 1'b1, 1'b0, 1'b0, 2'd0});
      b_rows.push_back('{1, 7,  1'b1, 1'b1, 32'h200, 32'h2222_2222, 1'b1, 1'b0, 1'b0, 2'd0});
      b_rows.push_back('{1, 8,  1'b1, 1'b0, 32'h300, 32'h3333_3333, 1'b1, 1'b0, 1'b1, 2'd1});
      b_rows.push_back('{1, 9,  1'b1, 1'b1, 32'h300, 32'h3333_3333, 1'b1, 1'b0, 1'b1, 2'd1});
      b_rows.push_back('{1, 10, 1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b1, 1'b1, 2'd1});
      // Entry 0 never ready: 8 ACCESS cycles, one idle cycle, then entry 1.
      b_rows.push_back('{2, 12, 1'b1, 1'b1, 32'h100, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 2'd0});
      b_rows.push_back('{2, 13, 1'b0, 1'b0, 32'h100, 32'h1111_1111, 1'b1, 1'b0, 1'b1, 2'd0});
      b_rows.push_back('{2, 14, 1'b1, 1'b0, 32'h200, 32'h2222_2222, 1'b1, 1'b0, 1'b1, 2'd0});
      b_rows.push_back('{2, 15, 1'b1, 1'b1, 32'h200, 32'h2222_2222, 1'b1, 1'b0, 1'b1, 2'd0});
      b_rows.push_back('{2, 16, 1'b1, 1'b0, 32'h300, 32'h3333_3333, 1'b1, 1'b0, 1'b1, 2'd0});
      b_rows.push_back('{2, 18, 1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b1, 1'b1, 2'd0});
      // Ready arrives in the timeout-expiry cycle: no error, normal progression.
      b_rows.push_back('{3, 12, 1'b1, 1'b1, 32'h100, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 2'd0});
      b_rows.push_back('{3, 13, 1'b1, 1'b0, 32'h200, 32'h2222_2222, 1'b1, 1'b0, 1'b0, 2'd0});
      b_rows.push_back('{3, 30, 1'b1, 1'b1, 32'h300, 32'h3333_3333, 1'b1, 1'b0, 1'b0, 2'd0});
      b_rows.push_back('{3, 31, 1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b1, 1'b0, 2'd0});

      a_rst_n = 1'b0; a_start = 1'b0;
      a_h_psel = 1'b1; a_h_penable = 1'b1; a_h_pwrite = 1'b1;
      a_h_paddr = 32'h0000_1234; a_h_pwdata = 32'hCAFE_F00D;
      a_prdata = 32'h5A5A_0001; a_pready = 1'b1; a_pslverr = 1'b0;
      b_rst_n = 1'b0; b_start = 1'b0;
      b_h_psel = 1'b0; b_h_penable = 1'b0; b_h_pwrite = 1'b0;
      b_h_paddr = 32'h0; b_h_pwdata = 32'h0; b_prdata = 32'h0;

      // ---- Instance A: reset values, timing, host stall, pass-through ----
      repeat (3) @(negedge clk);
      #1 chk("a_reset", a_obs, 128'h0);
      @(negedge clk) a_rst_n = 1'b1;
      #1 chk("a_cycle0", a_obs, 128'h0);
      // Start pulse outside DONE must not disturb the walk.
      goto_a(3); a_start = 1'b1;
      goto_a(4); a_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         goto_a(a_rows[i].cyc);
         #1 chk($sformatf("a_row_c%0d", a_rows[i].cyc), a_obs,
                {a_rows[i].psel, a_rows[i].pen, a_rows[i].pwr, a_rows[i].paddr,
                 a_rows[i].pwdata, a_rows[i].hrdy, a_rows[i].hrdata, a_rows[i].busy,
                 a_rows[i].done, a_rows[i].err, 1'b0});
      end

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a_h_psel = pt_vecs[i].hsel; a_h_penable = pt_vecs[i].hen; a_h_pwrite = pt_vecs[i].hwr;
         a_h_paddr = pt_vecs[i].haddr; a_h_pwdata = pt_vecs[i].hwdata;
         a_prdata = pt_vecs[i].prdata; a_pready = pt_vecs[i].prdy; a_pslverr = pt_vecs[i].perr;
         #1 chk($sformatf("a_passthru_%0d", i),
                {a_psel, a_penable, a_pwrite, a_paddr, a_pwdata, a_h_prdata, a_h_pready,
                 a_h_pslverr},
                {pt_vecs[i].e_psel, pt_vecs[i].e_pen, pt_vecs[i].e_pwr, pt_vecs[i].e_paddr,
                 pt_vecs[i].e_pwdata, pt_vecs[i].e_hrdata, pt_vecs[i].e_hrdy,
                 pt_vecs[i].e_herr});
      end

      // Rerun requested while the host holds psel: deferred until psel falls.
      @(negedge clk);
      a_h_psel = 1'b1; a_h_penable = 1'b0; a_pready = 1'b0; a_pslverr = 1'b0;
      a_start = 1'b1;
      @(negedge clk) a_start = 1'b0;
      #1 chk("a_start_deferred", {a_done, a_busy, a_psel}, {1'b1, 1'b0, 1'b1});
      @(negedge clk);
      #1 chk("a_start_still_deferred", {a_done, a_busy, a_psel}, {1'b1, 1'b0, 1'b1});
      a_h_psel = 1'b0;
      @(negedge clk);
      #1 chk("a_rerun_setup",
             {a_psel, a_penable, a_pwrite, a_paddr, a_pwdata, a_busy, a_done, a_err},
             {1'b1, 1'b0, 1'b1, 32'h0300_0210, 32'h004C_4B40, 1'b1, 1'b0, 1'b0});
      @(negedge clk);
      #1 chk("a_rerun_access", {a_psel, a_penable, a_busy}, {1'b1, 1'b1, 1'b1});
      #2 a_rst_n = 1'b0;
      #1 chk("a_reset_mid_write", a_obs, 128'h0);

      // ---- Instance B: table order, wait states, errors, timeout ----
      for (int s = 0; s < 4; s++) begin
         b_rst_n = 1'b0;
         b_ws = b_cfg[s].ws; b_err1 = b_cfg[s].err1; b_err2 = b_cfg[s].err2;
         b_hang = b_cfg[s].hang;
         repeat (2) @(negedge clk);
         b_rst_n = 1'b1;
         gaps0 = b_gaps;
         foreach (b_rows[i]) begin
            if (b_rows[i].scen == s) begin
               goto_b(b_rows[i].cyc);
               #1 chk($sformatf("b_s%0d_c%0d", s, b_rows[i].cyc), b_obs,
                      {b_rows[i].psel, b_rows[i].pen, b_rows[i].psel, b_rows[i].paddr,
                       b_rows[i].pwdata, b_rows[i].busy, b_rows[i].done, b_rows[i].err,
                       b_rows[i].eidx});
            end
         end
         chk($sformatf("b_s%0d_psel_gaps", s), 128'(b_gaps - gaps0),
             (s == 2) ? 128'd1 : 128'd0);
         if (s == 1) begin
            // Rerun from DONE with the host idle clears the error status.
            @(negedge clk) b_start = 1'b1;
            @(negedge clk) b_start = 1'b0;
            #1 chk("b_rerun_clears", b_obs,
                   {1'b1, 1'b0, 1'b1, 32'h100, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 2'd0});
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
